// File: rtl/pending_rd_scoreboard.sv
// pending_rd_scoreboard
// Issue-side RAW/WAW hazard scoreboard for the pipelined multicycle units.
// One countdown per register (integer file and FP file) tracks how many
// cycles remain until that register's in-flight result is written back.
// Optional feature macro: SCOREBOARD_FWD_EN -- when defined, a source whose
// producer writes back this cycle (count == 1) is forwarded, so it is not a
// RAW hazard. WAW detection is the same in both builds.
module pending_rd_scoreboard #(
    parameter int unsigned RD_ADDR_SIZE = 5,
    parameter int unsigned MAX_LAT      = 8,
    parameter int unsigned CNT_W        = $clog2(MAX_LAT + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wen,
    input  logic                        flush,
    input  logic                        issue_valid,
    input  logic [RD_ADDR_SIZE-1:0]     issue_rd,
    input  logic                        issue_reg_write,
    input  logic                        issue_FP_reg_write,
    input  logic [CNT_W-1:0]            issue_latency,
    input  logic [RD_ADDR_SIZE-1:0]     rs1_addr,
    input  logic                        rs1_fp,
    input  logic                        rs1_used,
    input  logic [RD_ADDR_SIZE-1:0]     rs2_addr,
    input  logic                        rs2_fp,
    input  logic                        rs2_used,
    input  logic [RD_ADDR_SIZE-1:0]     rs3_addr,
    input  logic                        rs3_fp,
    input  logic                        rs3_used,
    output logic                        stall,
    output logic [2**RD_ADDR_SIZE-1:0]  busy_int,
    output logic [2**RD_ADDR_SIZE-1:0]  busy_fp
);

    localparam int unsigned      NREG    = 2 ** RD_ADDR_SIZE;
    localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(MAX_LAT);

`ifdef SCOREBOARD_FWD_EN
    // A count of 1 means the producer writes back this cycle; the bypass
    // network covers that case, so only counts above 1 block a reader.
    localparam logic [CNT_W-1:0] RAW_THRESH = CNT_W'(1);
`else
    // Without forwarding every pending count blocks a reader.
    localparam logic [CNT_W-1:0] RAW_THRESH = '0;
`endif

    // Per-register remaining-latency counters
    logic [CNT_W-1:0] cnt_int [NREG];
    logic [CNT_W-1:0] cnt_fp  [NREG];

    // Source operand view, gathered so the RAW lookup can loop over it
    logic [RD_ADDR_SIZE-1:0] rs_addr [3];
    logic [2:0]              rs_fp;
    logic [2:0]              rs_used;

    logic [CNT_W-1:0] lat_sat;
    logic [CNT_W-1:0] src_cnt;
    logic [CNT_W-1:0] dst_int_cnt;
    logic [CNT_W-1:0] dst_fp_cnt;
    logic             dest_int_en;
    logic             dest_fp_en;
    logic             raw;
    logic             waw_int;
    logic             waw_fp;
    logic             accept;
    logic             load_int;
    logic             load_fp;

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;
    assign rs_addr[2] = rs3_addr;
    assign rs_fp      = {rs3_fp, rs2_fp, rs1_fp};
    assign rs_used    = {rs3_used, rs2_used, rs1_used};

    // Clamp the requested latency and qualify the destination per file
    always_comb begin
        lat_sat     = (issue_latency > LAT_MAX) ? LAT_MAX : issue_latency;
        dest_int_en = issue_reg_write && (issue_rd != '0);
        dest_fp_en  = issue_FP_reg_write;
    end

    // RAW: any used source whose producer is still far enough away
    always_comb begin
        raw     = 1'b0;
        src_cnt = '0;
        for (int unsigned s = 0; s < 3; s++) begin
            src_cnt = rs_fp[s] ? cnt_fp[rs_addr[s]] : cnt_int[rs_addr[s]];
            if (rs_used[s] && (rs_fp[s] || (rs_addr[s] != '0)) &&
                (src_cnt > RAW_THRESH)) begin
                raw = 1'b1;
            end
        end
    end

    // WAW: younger write would land no later than the older pending one
    always_comb begin
        dst_int_cnt = cnt_int[issue_rd];
        dst_fp_cnt  = cnt_fp[issue_rd];
        waw_int     = dest_int_en && (dst_int_cnt != '0) && (lat_sat <= dst_int_cnt);
        waw_fp      = dest_fp_en  && (dst_fp_cnt  != '0) && (lat_sat <= dst_fp_cnt);
    end

    // Hazard output and issue acceptance (combinational, never registered)
    always_comb begin
        stall    = issue_valid && (raw || waw_int || waw_fp);
        accept   = issue_valid && wen && !stall && !flush;
        load_int = accept && dest_int_en && (lat_sat != '0);
        load_fp  = accept && dest_fp_en  && (lat_sat != '0);
    end

    // Integer-file countdowns: flush clears, load beats decrement, wen=0 holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_int[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_int[i] <= '0;
            end
        end else if (wen) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (load_int && (issue_rd == RD_ADDR_SIZE'(i))) begin
                    cnt_int[i] <= lat_sat;
                end else if (cnt_int[i] != '0) begin
                    cnt_int[i] <= cnt_int[i] - CNT_W'(1);
                end
            end
        end
    end

    // FP-file countdowns: same policy as the integer file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_fp[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_fp[i] <= '0;
            end
        end else if (wen) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (load_fp && (issue_rd == RD_ADDR_SIZE'(i))) begin
                    cnt_fp[i] <= lat_sat;
                end else if (cnt_fp[i] != '0) begin
                    cnt_fp[i] <= cnt_fp[i] - CNT_W'(1);
                end
            end
        end
    end

    // Busy flags are simply the nonzero counts
    always_comb begin
        busy_int = '0;
        busy_fp  = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_int[i] = (cnt_int[i] != '0);
            busy_fp[i]  = (cnt_fp[i]  != '0);
        end
    end

endmodule

// File: tb/tb_pending_rd_scoreboard.sv
// Testbench for pending_rd_scoreboard: directed stimulus pushes the expected
// stall/busy state for each cycle into a queue; a monitor on the falling edge
// pops and compares against the DUT.
module tb_pending_rd_scoreboard;

    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;
    localparam int unsigned CW = 4;

`ifdef SCOREBOARD_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    localparam logic [NR-1:0] B3  = 32'd1 << 3;
    localparam logic [NR-1:0] B5  = 32'd1 << 5;
    localparam logic [NR-1:0] B7  = 32'd1 << 7;
    localparam logic [NR-1:0] B9  = 32'd1 << 9;
    localparam logic [NR-1:0] B10 = 32'd1 << 10;
    localparam logic [NR-1:0] B20 = 32'd1 << 20;

    logic          clk;
    logic          reset_n;
    logic          wen;
    logic          flush;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_reg_write;
    logic          issue_FP_reg_write;
    logic [CW-1:0] issue_latency;
    logic [AW-1:0] rs1_addr, rs2_addr, rs3_addr;
    logic          rs1_fp, rs2_fp, rs3_fp;
    logic          rs1_used, rs2_used, rs3_used;
    logic          stall;
    logic [NR-1:0] busy_int;
    logic [NR-1:0] busy_fp;

    typedef struct {
        string         name;
        logic          st;
        logic [NR-1:0] bi;
        logic [NR-1:0] bf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pending_rd_scoreboard #(
        .RD_ADDR_SIZE(AW),
        .MAX_LAT(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wen(wen),
        .flush(flush),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write),
        .issue_FP_reg_write(issue_FP_reg_write),
        .issue_latency(issue_latency),
        .rs1_addr(rs1_addr),
        .rs1_fp(rs1_fp),
        .rs1_used(rs1_used),
        .rs2_addr(rs2_addr),
        .rs2_fp(rs2_fp),
        .rs2_used(rs2_used),
        .rs3_addr(rs3_addr),
        .rs3_fp(rs3_fp),
        .rs3_used(rs3_used),
        .stall(stall),
        .busy_int(busy_int),
        .busy_fp(busy_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation mid-cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL %s stall: got %b want %b", e.name, stall, e.st);
            end
            checks++;
            if (busy_int !== e.bi) begin
                errors++;
                $display("FAIL %s busy_int: got %h want %h", e.name, busy_int, e.bi);
            end
            checks++;
            if (busy_fp !== e.bf) begin
                errors++;
                $display("FAIL %s busy_fp: got %h want %h", e.name, busy_fp, e.bf);
            end
        end
    end

    task automatic chk(input string n, input logic s, input logic [NR-1:0] bi,
                       input logic [NR-1:0] bf);
        exp_t e;
        e.name = n;
        e.st   = s;
        e.bi   = bi;
        e.bf   = bf;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string n, input logic s, input logic [NR-1:0] bi,
                        input logic [NR-1:0] bf);
        chk(n, s, bi, bf);
        tick();
    endtask

    task automatic iss(input logic [AW-1:0] rd, input logic iw, input logic fw,
                       input logic [CW-1:0] lat);
        issue_valid        = 1'b1;
        issue_rd           = rd;
        issue_reg_write    = iw;
        issue_FP_reg_write = fw;
        issue_latency      = lat;
    endtask

    task automatic idle();
        issue_valid        = 1'b0;
        issue_rd           = '0;
        issue_reg_write    = 1'b0;
        issue_FP_reg_write = 1'b0;
        issue_latency      = '0;
        rs1_used           = 1'b0;
        rs2_used           = 1'b0;
        rs3_used           = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        wen      = 1'b1;
        flush    = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rs3_addr = '0;
        rs1_fp   = 1'b0; rs2_fp = 1'b0; rs3_fp = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        step("reset", 1'b0, '0, '0);
        reset_n = 1'b1;
        step("idle", 1'b0, '0, '0);

        // FP rd3, latency 4: busy for exactly 4 cycles
        iss(5'd3, 1'b0, 1'b1, 4'd4);
        step("fp3_issue", 1'b0, '0, '0);
        idle();
        for (int k = 0; k < 4; k++) step("fp3_busy", 1'b0, '0, B3);
        step("fp3_clear", 1'b0, '0, '0);

        // RAW on integer rd5, latency 3
        iss(5'd5, 1'b1, 1'b0, 4'd3);
        step("raw_issue", 1'b0, '0, '0);
        idle();
        issue_valid = 1'b1;
        rs1_addr = 5'd5; rs1_fp = 1'b0; rs1_used = 1'b1;
        step("raw_c3", 1'b1, B5, '0);
        step("raw_c2", 1'b1, B5, '0);
        step("raw_c1", !FWD, B5, '0);
        step("raw_c0", 1'b0, '0, '0);
        idle();

        // Source looked up in the wrong file must not stall
        iss(5'd5, 1'b1, 1'b0, 4'd2);
        step("xf_issue", 1'b0, '0, '0);
        idle();
        issue_valid = 1'b1;
        rs2_addr = 5'd5; rs2_fp = 1'b1; rs2_used = 1'b1;
        step("xf_fpfile", 1'b0, B5, '0);
        rs2_fp = 1'b0;
        step("xf_intfile", !FWD, B5, '0);
        idle();
        rs2_fp = 1'b0;
        step("xf_clear", 1'b0, '0, '0);

        // WAW: FP rd7 L=6, later rd7 L=2 held until count drops below 2
        iss(5'd7, 1'b0, 1'b1, 4'd6);
        step("waw_issue", 1'b0, '0, '0);
        idle();
        step("waw_c6", 1'b0, '0, B7);
        step("waw_c5", 1'b0, '0, B7);
        iss(5'd7, 1'b0, 1'b1, 4'd2);
        step("waw_hold4", 1'b1, '0, B7);
        step("waw_hold3", 1'b1, '0, B7);
        step("waw_hold2", 1'b1, '0, B7);
        step("waw_go1", 1'b0, '0, B7);
        idle();
        step("waw_new2", 1'b0, '0, B7);
        step("waw_new1", 1'b0, '0, B7);
        step("waw_clear", 1'b0, '0, '0);

        // WAW with L=5 against count 4: accepted at once, reload to 5
        iss(5'd7, 1'b0, 1'b1, 4'd6);
        step("waw5_issue", 1'b0, '0, '0);
        idle();
        step("waw5_c6", 1'b0, '0, B7);
        step("waw5_c5", 1'b0, '0, B7);
        iss(5'd7, 1'b0, 1'b1, 4'd5);
        step("waw5_go4", 1'b0, '0, B7);
        idle();
        for (int k = 0; k < 5; k++) step("waw5_busy", 1'b0, '0, B7);
        step("waw5_clear", 1'b0, '0, '0);

        // Freeze: L=4 with 3 frozen cycles stays busy 7 cycles
        iss(5'd9, 1'b1, 1'b0, 4'd4);
        step("frz_issue", 1'b0, '0, '0);
        idle();
        step("frz_run4", 1'b0, B9, '0);
        wen = 1'b0;
        for (int k = 0; k < 3; k++) step("frz_hold", 1'b0, B9, '0);
        wen = 1'b1;
        step("frz_run3", 1'b0, B9, '0);
        step("frz_run2", 1'b0, B9, '0);
        step("frz_run1", 1'b0, B9, '0);
        step("frz_clear", 1'b0, '0, '0);

        // Dual-file load, then flush together with a valid issue
        iss(5'd9, 1'b1, 1'b1, 4'd8);
        step("dual_issue", 1'b0, '0, '0);
        idle();
        step("dual_busy", 1'b0, B9, B9);
        iss(5'd12, 1'b1, 1'b0, 4'd5);
        flush = 1'b1;
        step("flush_cyc", 1'b0, B9, B9);
        flush = 1'b0;
        idle();
        step("flush_clr", 1'b0, '0, '0);
        step("flush_clr2", 1'b0, '0, '0);

        // Edge cases: integer x0, latency 0, latency 15 saturated to 8
        iss(5'd0, 1'b1, 1'b0, 4'd3);
        step("rd0_issue", 1'b0, '0, '0);
        idle();
        step("rd0_none", 1'b0, '0, '0);
        iss(5'd10, 1'b1, 1'b0, 4'd0);
        step("lat0_issue", 1'b0, '0, '0);
        idle();
        step("lat0_none", 1'b0, '0, '0);
        iss(5'd10, 1'b1, 1'b0, 4'd15);
        step("lat15_issue", 1'b0, '0, '0);
        idle();
        for (int k = 0; k < 8; k++) step("lat15_busy", 1'b0, B10, '0);
        step("lat15_clear", 1'b0, '0, '0);

        // Asynchronous reset mid-countdown clears without a clock edge
        iss(5'd20, 1'b0, 1'b1, 4'd8);
        step("rst_issue", 1'b0, '0, '0);
        idle();
        step("rst_busy8", 1'b0, '0, B20);
        step("rst_busy7", 1'b0, '0, B20);
        reset_n = 1'b0;
        #1;
        chk("rst_async", 1'b0, '0, '0);
        tick();
        reset_n = 1'b1;
        step("rst_after", 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
